// File: rtl/branch_unit_bht.sv
// rtl/branch_unit_bht.sv - RV32I/RV64I branch resolve unit with a direct-mapped BHT,
// registered mispredict flush and saturating branch statistics.
module branch_unit_bht #(
   parameter int XLEN      = 32,
   parameter int BHT_IDX_W = 4,
   parameter int CNT_W     = 2,
   parameter int STAT_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [XLEN-1:0]   lookup_pc,
   output logic              predict_taken,
   input  logic              ex_valid,
   input  logic              ex_branch,
   input  logic [2:0]        ex_funct3,
   input  logic [XLEN-1:0]   ex_pc,
   input  logic [XLEN-1:0]   ex_rs1,
   input  logic [XLEN-1:0]   ex_rs2,
   input  logic [XLEN-1:0]   ex_target,
   input  logic              ex_pred_taken,
   output logic              taken,
   output logic              illegal_br,
   output logic              mispredict,
   output logic [XLEN-1:0]   redirect_pc,
   output logic [STAT_W-1:0] br_count,
   output logic [STAT_W-1:0] miss_count
);

   localparam int              ENTRIES = 1 << BHT_IDX_W;
   localparam logic [CNT_W-1:0] C_WNT  = CNT_W'((1 << (CNT_W - 1)) - 1);
   localparam logic [CNT_W-1:0] C_MAX  = '1;

   logic [CNT_W-1:0]     r_bht [ENTRIES];
   logic                 r_mispredict;
   logic [XLEN-1:0]      r_redirect_pc;
   logic [STAT_W-1:0]    r_br_count;
   logic [STAT_W-1:0]    r_miss_count;

   logic [BHT_IDX_W-1:0] w_lookup_idx;
   logic [BHT_IDX_W-1:0] w_ex_idx;
   logic [CNT_W-1:0]     w_ex_cnt;
   logic                 w_resolve;
   logic                 w_cond;
   logic                 w_next_miss;
   logic [XLEN-1:0]      w_next_pc;
   logic                 w_unused_pc_bits;

   assign w_lookup_idx     = lookup_pc[BHT_IDX_W+1:2];
   assign w_ex_idx         = ex_pc[BHT_IDX_W+1:2];
   assign w_ex_cnt         = r_bht[w_ex_idx];
   assign w_unused_pc_bits = ^{lookup_pc[XLEN-1:BHT_IDX_W+2], lookup_pc[1:0]};

   // Read straight from the array: a same-cycle update is not bypassed.
   assign predict_taken = r_bht[w_lookup_idx][CNT_W-1];

   assign illegal_br = ex_valid & ex_branch & (ex_funct3[2:1] == 2'b01);
   assign w_resolve  = ex_valid & ex_branch & ~illegal_br;

   always_comb begin
      w_cond = 1'b0;
      case (ex_funct3)
         3'b000:  w_cond = (ex_rs1 == ex_rs2);
         3'b001:  w_cond = (ex_rs1 != ex_rs2);
         3'b100:  w_cond = ($signed(ex_rs1) <  $signed(ex_rs2));
         3'b101:  w_cond = ($signed(ex_rs1) >= $signed(ex_rs2));
         3'b110:  w_cond = (ex_rs1 <  ex_rs2);
         3'b111:  w_cond = (ex_rs1 >= ex_rs2);
         default: w_cond = 1'b0;
      endcase
   end

   assign taken       = w_resolve & w_cond;
   assign w_next_miss = w_resolve & (taken != ex_pred_taken);
   assign w_next_pc   = taken ? ex_target : (ex_pc + XLEN'(4));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) r_bht[i] <= C_WNT;
      end else if (w_resolve) begin
         if (taken && (w_ex_cnt != C_MAX))
            r_bht[w_ex_idx] <= w_ex_cnt + CNT_W'(1);
         else if (!taken && (w_ex_cnt != '0))
            r_bht[w_ex_idx] <= w_ex_cnt - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mispredict  <= 1'b0;
         r_redirect_pc <= '0;
         r_br_count    <= '0;
         r_miss_count  <= '0;
      end else begin
         r_mispredict <= w_next_miss;
         if (w_next_miss)
            r_redirect_pc <= w_next_pc;
         if (w_resolve && (r_br_count != '1))
            r_br_count <= r_br_count + STAT_W'(1);
         if (w_next_miss && (r_miss_count != '1))
            r_miss_count <= r_miss_count + STAT_W'(1);
      end
   end

   assign mispredict  = r_mispredict;
   assign redirect_pc = r_redirect_pc;
   assign br_count    = r_br_count;
   assign miss_count  = r_miss_count;

endmodule

// File: doc/branch_unit_bht.md
Name: branch_unit_bht

Overview:
Parametrised successor to the single-cycle branch decision logic.
- Resolves all six RV32I/RV64I conditional branches in EX: BEQ, BNE, BLT, BGE, BLTU, BGEU.
- Keeps a direct-mapped branch history table (BHT) of saturating counters, read by IF/ID for prediction and written by EX on resolution.
- Produces a registered mispredict/flush pulse, the redirect PC and saturating performance counters for the pipeline hazard unit.

Parameters:
- XLEN, 32, operand and PC width.
- BHT_IDX_W, 4, log2 of BHT entries (entries = 2^BHT_IDX_W); legal range 1..10.
- CNT_W, 2, width of each BHT saturating counter; legal range 1..4.
- STAT_W, 16, width of each performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- lookup_pc  in  XLEN  PC of the instruction in IF/ID being predicted.
- predict_taken  out  1  combinational prediction for lookup_pc.
- ex_valid  in  1  EX stage holds a valid instruction (not bubble/flushed).
- ex_branch  in  1  EX instruction is a conditional branch.
- ex_funct3  in  3  branch type.
- ex_pc  in  XLEN  PC of the EX instruction.
- ex_rs1, ex_rs2  in  XLEN each  forwarded operands.
- ex_target  in  XLEN  computed branch target (pc+imm).
- ex_pred_taken  in  1  prediction carried down the pipe with the instruction.
- taken  out  1  combinational actual outcome.
- illegal_br  out  1  combinational; ex_valid & ex_branch & funct3 in {010, 011}.
- mispredict  out  1  registered one-cycle flush pulse.
- redirect_pc  out  XLEN  registered correct next PC; valid when mispredict=1.
- br_count  out  STAT_W  resolved branches.
- miss_count  out  STAT_W  mispredicted branches.

Behaviour:
- Reset (async, rst_n=0):
  - all BHT entries = weakly-not-taken, i.e. 2^(CNT_W-1)-1; for CNT_W=1 this is 0.
  - mispredict=0, redirect_pc=0, br_count=0, miss_count=0.
  - Reset asserted mid-operation discards any pending update or pulse in that cycle.
- resolve = ex_valid & ex_branch & ~illegal_br.
- Condition decode, all combinational:
  - 000 BEQ: rs1==rs2.
  - 001 BNE: rs1!=rs2.
  - 100 BLT: signed rs1<rs2.
  - 101 BGE: signed rs1>=rs2.
  - 110 BLTU: unsigned rs1<rs2.
  - 111 BGEU: unsigned rs1>=rs2.
  - taken = resolve & condition. Illegal funct3 gives taken=0 and no update.
- Index = pc[BHT_IDX_W+1:2]; bits [1:0] are ignored.
- predict_taken = MSB of BHT[index(lookup_pc)]; asynchronous read.
- Update on the rising edge when resolve=1: BHT[index(ex_pc)] increments if taken, else decrements. Saturates at 2^CNT_W-1 and at 0; no wrap.
- Same-cycle lookup and update of the same index: predict_taken reflects the pre-update value. No bypass.
- Mispredict, registered, 1-cycle latency:
  - next mispredict = resolve & (taken != ex_pred_taken).
  - next redirect_pc = taken ? ex_target : ex_pc+4, modulo 2^XLEN.
  - redirect_pc holds its value when mispredict=0.
  - mispredict is a single-cycle pulse per mispredicted branch. Back-to-back mispredicting branches give consecutive pulses.
- Stats: br_count+1 on resolve; miss_count+1 on next-mispredict. Both saturate at all-ones.
- ex_valid=0 or ex_branch=0: no BHT, stat or mispredict activity. taken=0; mispredict goes 0 next cycle.

Test Plan:
- Reset, then lookup_pc=0x40 -> predict_taken=0. After deassert, br_count=0, miss_count=0, mispredict=0.
- BLT rs1=0xFFFFFFFF, rs2=1, pred=0, pc=0x100, target=0x80 -> taken=1; next cycle mispredict=1, redirect_pc=0x80, miss_count=1. BLTU with the same operands -> taken=0.
- Three taken BEQ at pc=0x20 (rs1=rs2=5) -> counter 01->10->11->11. predict_taken for 0x20 goes 1 after the first update. pc=0x60 (same index, BHT_IDX_W=4) aliases and predicts 1.
- BNE not-taken at pc=0x104 with pred=1 -> mispredict pulse, redirect_pc=0x108. pc=0xFFFFFFFC not-taken, pred=1 -> redirect_pc=0x0 (wrap).
- funct3=010 with ex_valid=1, ex_branch=1 -> illegal_br=1, taken=0, no counter or stat change. ex_valid=0 with BEQ equal operands -> no activity.
- Preload br_count to 0xFFFF via 65535 resolves -> stays 0xFFFF after more resolves. Assert rst_n low mid-stream with mispredict=1 -> all outputs and BHT return to reset values immediately.
